// File: rtl/poly_horner_eval.sv
// poly_horner_eval: evaluates c_N*x^N + ... + c_1*x + c_0 (mod 2^WIDTH) with Horner's method.
// A single multiply/add unit is shared: each coefficient after c_N takes one MUL cycle and one ADD cycle.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (abandons any running evaluation)
//   start   request; only sampled while idle, x and coef are captured on accept
//   x       evaluation point (WIDTH bits)
//   coef    packed coefficients, c_i = coef[i*WIDTH +: WIDTH]
//   busy    high while an evaluation is running
//   done    one-cycle pulse when result is updated
//   ovf     (only with POLY_HORNER_OVF_EN) sticky flag: some product or sum exceeded WIDTH bits
//   result  last completed value, held until the next completion
// Optional feature macro: POLY_HORNER_OVF_EN
module poly_horner_eval #(
   parameter int WIDTH  = 16,
   parameter int DEGREE = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [WIDTH-1:0]              x,
   input  logic [(DEGREE+1)*WIDTH-1:0]   coef,
   output logic                          busy,
   output logic                          done,
`ifdef POLY_HORNER_OVF_EN
   output logic                          ovf,
`endif
   output logic [WIDTH-1:0]              result
);
   typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;
   // Products and sums keep their carry bits only when overflow detection needs them.
`ifdef POLY_HORNER_OVF_EN
   localparam int PW = 2 * WIDTH;
   localparam int SW = WIDTH + 1;
`else
   localparam int PW = WIDTH;
   localparam int SW = WIDTH;
`endif
   state_t                        state, state_n;
   logic [WIDTH-1:0]              x_reg, x_n;
   logic [WIDTH-1:0]              acc, acc_n;
   logic [WIDTH-1:0]              result_n;
   logic [WIDTH-1:0]              c_k;
   logic [(DEGREE+1)*WIDTH-1:0]   coef_reg, coef_n;
   logic [3:0]                    k, k_n;
   logic                          done_n;
   logic [PW-1:0]                 prod;
   logic [SW-1:0]                 sum;
`ifdef POLY_HORNER_OVF_EN
   logic                          ovf_n;
`endif
   assign c_k  = coef_reg[int'(k)*WIDTH +: WIDTH];
   assign prod = PW'(acc) * PW'(x_reg);
   assign sum  = SW'(acc) + SW'(c_k);
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         x_reg    <= '0;
         coef_reg <= '0;
         acc      <= '0;
         k        <= '0;
         result   <= '0;
         done     <= 1'b0;
`ifdef POLY_HORNER_OVF_EN
         ovf      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         x_reg    <= x_n;
         coef_reg <= coef_n;
         acc      <= acc_n;
         k        <= k_n;
         result   <= result_n;
         done     <= done_n;
`ifdef POLY_HORNER_OVF_EN
         ovf      <= ovf_n;
`endif
      end
   end
   always_comb begin
      state_n  = state;
      x_n      = x_reg;
      coef_n   = coef_reg;
      acc_n    = acc;
      k_n      = k;
      result_n = result;
      done_n   = 1'b0;
`ifdef POLY_HORNER_OVF_EN
      ovf_n    = ovf;
`endif
      case (state)
         IDLE: if (start) begin
            x_n    = x;
            coef_n = coef;
`ifdef POLY_HORNER_OVF_EN
            ovf_n  = 1'b0;
`endif
            // A constant polynomial needs no arithmetic: publish c_0 directly.
            if (DEGREE == 0) begin
               result_n = coef[WIDTH-1:0];
               done_n   = 1'b1;
            end else begin
               acc_n   = coef[DEGREE*WIDTH +: WIDTH];
               k_n     = 4'(DEGREE - 1);
               state_n = MUL;
            end
         end
         MUL: begin
            acc_n   = prod[WIDTH-1:0];
`ifdef POLY_HORNER_OVF_EN
            ovf_n   = ovf | (|prod[PW-1:WIDTH]);
`endif
            state_n = ADD;
         end
         ADD: begin
`ifdef POLY_HORNER_OVF_EN
            ovf_n = ovf | sum[WIDTH];
`endif
            if (k == 4'd0) begin
               result_n = sum[WIDTH-1:0];
               done_n   = 1'b1;
               state_n  = IDLE;
            end else begin
               acc_n   = sum[WIDTH-1:0];
               k_n     = k - 4'd1;
               state_n = MUL;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
- Self-sequenced, parametrised polynomial evaluator: result = c_N·x^N + … + c_1·x + c_0 (mod 2^WIDTH).
- Uses Horner's method on a single shared multiply/add unit, alternating a multiply step and an add step.
- Integrates the datapath (operand registers, accumulator, step counter) with its own controller, so no external state sequencing is needed.
- Start/done handshake; sits between the stimulus/control logic and any consumer of the evaluated value.

Parameters:
- WIDTH, 16, bit width of x, of each coefficient, of the accumulator and of result.
- DEGREE, 2, polynomial degree N (N+1 coefficients); legal range 0..15.

Ports:
- clk  input  1  clock, rising edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new evaluation; sampled only in IDLE.
- x  input  WIDTH  evaluation point; captured on the start-accept edge.
- coef  input  (DEGREE+1)*WIDTH  packed coefficients; slice i = coef[i*WIDTH +: WIDTH] = c_i (c_0 in LSBs); captured on the start-accept edge.
- busy  output  1  high while an evaluation is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH  last completed value; held until the next completion.

Behaviour:
- Single clock domain. All state changes on the rising edge of clk; rst is synchronous and active-high.
- Reset: state=IDLE; busy=0; done=0; result=0; accumulator, counter and operand registers=0. Reset has priority over every other input, including mid-operation; any in-flight evaluation is discarded and no done pulse is issued.
- States: IDLE, MUL, ADD.
- IDLE:
  - done defaults to 0 unless set by this edge.
  - start=1 accepts a request: capture x and all coefficients; acc<=c_N; k<=N-1; busy<=1; go to MUL.
  - Special case DEGREE=0: on accept, result<=c_0, done<=1, stay in IDLE, busy stays 0.
- MUL: acc <= (acc·x_reg)[WIDTH-1:0]; go to ADD.
- ADD: sum = (acc + c_k)[WIDTH-1:0].
  - If k==0: result<=sum; done<=1; busy<=0; go to IDLE.
  - Otherwise: acc<=sum; k<=k-1; go to MUL.
- Latency: done is high in the cycle after edge 2N, counting the accept edge as edge 0. For DEGREE=2 this is 4 edges after accept.
- done is high for exactly one cycle. busy and done are never high together.
- start while busy=1 is ignored: not queued, no effect. start sampled in the done cycle (state=IDLE) is accepted, giving back-to-back operation with no bubble.
- Changes to x or coef after accept do not affect the running evaluation.
- Arithmetic is unsigned and truncated to WIDTH bits at every step (wrap-around, no saturation).
- result changes only on a completion edge or on reset.

Optional Feature:
- Macro: POLY_HORNER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit). Reset value 0; cleared on the start-accept edge.
  - Set sticky when any MUL full product or any ADD carry exceeds WIDTH bits during the operation.
  - Its value is valid, and held, from the done cycle until the next accept.
  - For DEGREE=0 it is always 0.
- Undefined: port ovf is absent and no overflow logic is generated. All other behaviour is identical.

Test Plan:
- WIDTH=16, DEGREE=2; c2=2, c1=2, c0=1, x=2; pulse start -> busy=1 for 4 cycles; done pulse 4 edges after accept; result=13; ovf=0.
- Same coefficients, x=0 -> result=1. Then c2=c1=c0=0, x=7 -> result=0; done still arrives at 4-edge latency.
- c2=1, c1=0, c0=0, x=300 -> result=24464 (90000 mod 65536); with POLY_HORNER_OVF_EN, ovf=1. A following run with x=2 -> ovf cleared, result=4.
- Hold start=1 continuously with x=3, c2=1, c1=1, c0=1 -> each run gives result=13; accepts occur on every done cycle; done every 5 cycles; start pulses while busy do not change result or timing.
- Start an evaluation (x=2, coefs 2,2,1), assert rst for one cycle during the second MUL -> busy=0, done=0, result=0, no done pulse. A new start with x=1 -> result=5.
- Change x and coef on the cycle after accept -> result still reflects the captured values (13). For DEGREE=0, c0=42 -> done one edge after accept, result=42, busy never high.
